// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the PWM sample scheduler.
package pwm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRIME    = 2'd1,
        RUN      = 2'd2,
        UNDERRUN = 2'd3
    } sched_state_t;

    localparam int unsigned UNDERRUN_CNT_W = 16;

    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with flush; head word presented combinationally.
module sample_fifo #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      cnt;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (cnt == LVL_W'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// Paces buffered samples into the PWM stage, one per PWM period.
// Optional: define PWM_SCHED_HOLD_LAST_EN to hold the last sample during underrun.
module pwm_sample_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned COUNT_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PRIME_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [DATA_WIDTH-1:0]     pwm_data,
    output logic                      frame_tick,
    output logic [1:0]                state,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COUNT_WIDTH-1:0] TICK_PRE = {{(COUNT_WIDTH-1){1'b1}}, 1'b0};

    sched_state_t              state_q, state_d;
    logic [COUNT_WIDTH-1:0]    cnt_q;
    logic                      tick_q;
    logic [DATA_WIDTH-1:0]     pwm_q, pwm_d;
    logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;
    logic [DATA_WIDTH-1:0]     fifo_rdata;
    logic [DATA_WIDTH-1:0]     underrun_val;
    logic [LVL_W-1:0]          level;
    logic                      full, empty, push, pop, flush, primed;

    assign s_ready      = (state_q != IDLE) && !full;
    assign push         = s_valid && s_ready;
    assign primed       = (level >= LVL_W'(PRIME_LEVEL));
    assign pwm_data     = pwm_q;
    assign frame_tick   = tick_q;
    assign state        = 2'(state_q);
    assign underrun_cnt = ucnt_q;

    sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

`ifdef PWM_SCHED_HOLD_LAST_EN
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (!enable) begin
            hold_q <= '0;
        end else if (pop) begin
            hold_q <= fifo_rdata;
        end
    end

    assign underrun_val = hold_q;
`else
    assign underrun_val = '0;
`endif

    // Free-running frame counter; tick is registered so it aligns with the all-ones count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= (cnt_q == TICK_PRE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pwm_q   <= '0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pwm_q   <= pwm_d;
            ucnt_q  <= ucnt_d;
        end
    end

    // Pop decisions use the registered FIFO level; disable overrides everything.
    always_comb begin
        state_d = state_q;
        pwm_d   = pwm_q;
        ucnt_d  = ucnt_q;
        pop     = 1'b0;
        flush   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            flush   = 1'b1;
            pwm_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = PRIME;
                PRIME: begin
                    if (tick_q && primed) begin
                        pop     = 1'b1;
                        pwm_d   = fifo_rdata;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick_q) begin
                        if (!empty) begin
                            pop   = 1'b1;
                            pwm_d = fifo_rdata;
                        end else begin
                            state_d = UNDERRUN;
                            pwm_d   = underrun_val;
                            ucnt_d  = sat_inc(ucnt_q);
                        end
                    end
                end
                UNDERRUN: begin
                    if (tick_q) begin
                        if (primed) begin
                            pop     = 1'b1;
                            pwm_d   = fifo_rdata;
                            state_d = RUN;
                        end else begin
                            pwm_d  = underrun_val;
                            ucnt_d = sat_inc(ucnt_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Directed self-checking bench for pwm_sample_scheduler (period 16, depth 4, prime 2).
module tb_pwm_sample_scheduler;

    localparam int unsigned DW = 12;
`ifdef PWM_SCHED_HOLD_LAST_EN
    localparam logic [DW-1:0] UV_A = 12'h200;
    localparam logic [DW-1:0] UV_B = 12'h222;
`else
    localparam logic [DW-1:0] UV_A = 12'h000;
    localparam logic [DW-1:0] UV_B = 12'h000;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] pwm_data;
    logic          frame_tick;
    logic [1:0]    state;
    logic [15:0]   underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    pwm_sample_scheduler #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (4),
        .FIFO_DEPTH  (4),
        .PRIME_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .pwm_data     (pwm_data),
        .frame_tick   (frame_tick),
        .state        (state),
        .underrun_cnt (underrun_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Cycle k = k-th rising edge after reset release; sampled 1ns after that edge.
    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_pwm", 32'(pwm_data), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_ucnt", 32'(underrun_cnt), 0);
        chk("rst_ready", 32'(s_ready), 0);
        rst = 1'b0; cyc = 0; enable = 1'b1;

        // Prime with two samples, then play them out
        go_to(1);   chk("t1_prime", 32'(state), 1); chk("t1_ready", 32'(s_ready), 1);
        go_to(2);   s_valid = 1'b1; s_data = 12'h100;
        go_to(3);   s_data = 12'h200;
        go_to(4);   s_valid = 1'b0;
        go_to(14);  chk("t1_state14", 32'(state), 1); chk("t1_tick14", 32'(frame_tick), 0);
        go_to(15);  chk("t1_tick15", 32'(frame_tick), 1); chk("t1_pwm15", 32'(pwm_data), 0);
        go_to(16);  chk("t1_run", 32'(state), 2); chk("t1_pwm16", 32'(pwm_data), 12'h100);
                    chk("t1_tick16", 32'(frame_tick), 0);
        go_to(31);  chk("t1_pwm31", 32'(pwm_data), 12'h100); chk("t1_tick31", 32'(frame_tick), 1);
        go_to(32);  chk("t1_pwm32", 32'(pwm_data), 12'h200);

        // Starvation: underrun counting, then recovery
        go_to(47);  chk("t3_run47", 32'(state), 2);
        go_to(48);  chk("t3_ur", 32'(state), 3); chk("t3_pwm48", 32'(pwm_data), 32'(UV_A));
                    chk("t3_ucnt1", 32'(underrun_cnt), 1);
        go_to(64);  chk("t3_ucnt2", 32'(underrun_cnt), 2); chk("t3_ur64", 32'(state), 3);
        go_to(80);  chk("t3_ucnt3", 32'(underrun_cnt), 3); chk("t3_pwm80", 32'(pwm_data), 32'(UV_A));
        go_to(81);  s_valid = 1'b1; s_data = 12'h333;
        go_to(82);  s_data = 12'h444;
        go_to(83);  s_valid = 1'b0;
        go_to(95);  chk("t3_ur95", 32'(state), 3);
        go_to(96);  chk("t3_rerun", 32'(state), 2); chk("t3_pwm96", 32'(pwm_data), 12'h333);
                    chk("t3_ucnt96", 32'(underrun_cnt), 3);

        // Fill to full and hold a fifth sample on the input
        go_to(97);  s_valid = 1'b1; s_data = 12'h501;
        go_to(98);  s_data = 12'h502;
        go_to(99);  s_data = 12'h503;
        go_to(100); s_data = 12'h504; chk("t2_full100", 32'(s_ready), 0);
        go_to(111); chk("t2_full111", 32'(s_ready), 0); chk("t2_tick111", 32'(frame_tick), 1);
        go_to(112); chk("t2_ready112", 32'(s_ready), 1); chk("t2_pwm112", 32'(pwm_data), 12'h444);
        go_to(113); s_valid = 1'b0; chk("t2_full113", 32'(s_ready), 0);
        go_to(128); chk("t2_pwm128", 32'(pwm_data), 12'h501);
        go_to(144); chk("t2_pwm144", 32'(pwm_data), 12'h502);
        go_to(160); chk("t2_pwm160", 32'(pwm_data), 12'h503);
        go_to(176); chk("t2_pwm176", 32'(pwm_data), 12'h504); chk("t2_run176", 32'(state), 2);

        // Disable mid-period with three samples queued
        go_to(177); s_valid = 1'b1; s_data = 12'h601;
        go_to(178); s_data = 12'h602;
        go_to(179); s_data = 12'h603;
        go_to(180); s_valid = 1'b0;
        go_to(185); enable = 1'b0;
        go_to(186); chk("t5_idle", 32'(state), 0); chk("t5_pwm", 32'(pwm_data), 0);
                    chk("t5_ready", 32'(s_ready), 0); chk("t5_ucnt", 32'(underrun_cnt), 3);
                    enable = 1'b1;
        go_to(187); chk("t5_prime", 32'(state), 1);
        go_to(188); s_valid = 1'b1; s_data = 12'h0AA;
        go_to(189); s_data = 12'h0BB;
        go_to(190); s_valid = 1'b0;
        go_to(192); chk("t5_flushed", 32'(pwm_data), 12'h0AA); chk("t5_run", 32'(state), 2);
        go_to(208); chk("t5_pwm208", 32'(pwm_data), 12'h0BB);

        // Disable on a starving tick: IDLE wins, no underrun counted
        go_to(223); chk("bd_tick223", 32'(frame_tick), 1); enable = 1'b0;
        go_to(224); chk("bd_idle", 32'(state), 0); chk("bd_ucnt", 32'(underrun_cnt), 3);
                    chk("bd_pwm", 32'(pwm_data), 0); enable = 1'b1;
        go_to(225); chk("bd_prime", 32'(state), 1);
        go_to(226); s_valid = 1'b1; s_data = 12'h111;
        go_to(227); s_data = 12'h222;
        go_to(228); s_valid = 1'b0;
        go_to(240); chk("bd_pwm240", 32'(pwm_data), 12'h111);
        go_to(256); chk("bd_pwm256", 32'(pwm_data), 12'h222);

        // Push on a tick with empty FIFO is not seen by that tick
        go_to(271); s_valid = 1'b1; s_data = 12'h333; chk("bd_tick271", 32'(frame_tick), 1);
        go_to(272); s_data = 12'h444;
                    chk("bd_ur272", 32'(state), 3); chk("bd_ucnt272", 32'(underrun_cnt), 4);
                    chk("bd_pwm272", 32'(pwm_data), 32'(UV_B));
        go_to(273); s_valid = 1'b0;
        go_to(288); chk("bd_run288", 32'(state), 2); chk("bd_pwm288", 32'(pwm_data), 12'h333);
                    chk("bd_ucnt288", 32'(underrun_cnt), 4);

        // Asynchronous reset mid-period
        go_to(290); #2 rst = 1'b1;
        #1;
        chk("t6_state", 32'(state), 0); chk("t6_pwm", 32'(pwm_data), 0);
        chk("t6_tick", 32'(frame_tick), 0); chk("t6_ucnt", 32'(underrun_cnt), 0);
        chk("t6_ready", 32'(s_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0; cyc = 0;
        go_to(14);  chk("t6_tick14", 32'(frame_tick), 0);
        go_to(15);  chk("t6_tick15", 32'(frame_tick), 1); chk("t6_prime", 32'(state), 1);
        go_to(16);  chk("t6_tick16", 32'(frame_tick), 0); chk("t6_pwm16", 32'(pwm_data), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_sample_scheduler.md
Name: pwm_sample_scheduler

Overview:
- Paces audio/baseband samples from the demodulator chain into the PWM output stage.
- Buffers incoming samples in a small FIFO using a valid/ready handshake.
- Releases exactly one sample per PWM period, holding `pwm_data` stable for the whole period.
- Manages prime/run/underrun sequencing and feeds the PWM block's `data_in` directly.

Parameters:
- DATA_WIDTH, 12: sample width; equals PWM data width.
- COUNT_WIDTH, 10: PWM counter width; period = 2^COUNT_WIDTH clocks.
- FIFO_DEPTH, 4: sample buffer depth; power of two, >= 2.
- PRIME_LEVEL, 2: FIFO fill needed before (re)starting playback; 1..FIFO_DEPTH.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  playback enable; low = flush and idle
- s_data  input  DATA_WIDTH  incoming sample
- s_valid  input  1  s_data valid
- s_ready  output  1  scheduler accepts s_data this cycle
- pwm_data  output  DATA_WIDTH  sample to PWM data_in, constant within a period
- frame_tick  output  1  one-cycle pulse on the last clock of each period
- state  output  2  0=IDLE, 1=PRIME, 2=RUN, 3=UNDERRUN
- underrun_cnt  output  16  saturating count of periods with no sample

Behaviour:
Reset values (asynchronous):
- `pwm_data` = 0; `frame_tick` = 0; `state` = IDLE; `underrun_cnt` = 0.
- FIFO empty; frame counter = 0; `s_ready` = 0.

Frame counter:
- COUNT_WIDTH bits, free-running from reset in all states, wraps modulo 2^COUNT_WIDTH.
- `frame_tick` is registered: high for the single cycle in which the counter equals all-ones.

FIFO handshake:
- Transfer occurs when `s_valid && s_ready`.
- `s_ready` = (state != IDLE) && !full, combinational from registered level.
- A push and a pop in the same cycle leave the level unchanged.
- No push is possible when full; `s_data` is not consumed while `s_valid` is held.

Pop:
- Occurs only on a `frame_tick` cycle and only per the state machine below.
- Popped value lands in `pwm_data` one clock after the tick cycle, coincident with the counter wrapping to 0.
- `pwm_data` never changes at any other time.

State machine, evaluated each clock; `enable` = 0 has priority from any state:
- Any state, `enable` = 0: next state IDLE; FIFO flushed (level 0); `pwm_data` <- 0; `underrun_cnt` held.
- IDLE, `enable` = 1: go to PRIME.
- PRIME, tick with level >= PRIME_LEVEL: pop, go to RUN.
- PRIME, any other cycle: stay; `pwm_data` held.
- RUN, tick with level >= 1: pop.
- RUN, tick with FIFO empty: go to UNDERRUN; load the underrun value; `underrun_cnt`++.
- UNDERRUN, tick with level >= PRIME_LEVEL: pop, go to RUN.
- UNDERRUN, tick otherwise: reload the underrun value; `underrun_cnt`++.

Underrun rules:
- Underrun value is 0 (PWM adds its offset, giving midscale), unless the optional feature is enabled.
- `underrun_cnt` saturates at 0xFFFF; it clears only on `rst`.

Boundary cases:
- Push arriving on a tick cycle with the FIFO empty is not visible to that tick's pop decision; the decision uses the registered level.
- `enable` deasserted on a tick cycle: no pop occurs and `underrun_cnt` does not increment; IDLE takes priority.
- `rst` mid-period: all state returns to reset values immediately; the counter restarts at 0.

Optional Feature:
- Macro: PWM_SCHED_HOLD_LAST_EN.
- Defined: the underrun value is the last sample popped in RUN, so output stays at the last level instead of midscale. The held value resets to 0 on `rst` and on entering IDLE.
- Undefined: the underrun value is the constant 0.

Decomposition:
- Package `pwm_sched_pkg`:
  - `sched_state_t` enum (IDLE, PRIME, RUN, UNDERRUN; 2-bit encoding as listed in Ports).
  - UNDERRUN_CNT_W = 16.
- Sub-module `sample_fifo`: synchronous FIFO, parameterized by DATA_WIDTH and FIFO_DEPTH.
  - Ports: push, pop, flush, full, empty, level.
  - First-word data presented combinationally.
- The scheduler top holds the frame counter, FSM, output register and counters.

Test Plan:
Use COUNT_WIDTH=4 (period 16), FIFO_DEPTH=4, PRIME_LEVEL=2 throughout.
1. Reset, `enable`=1, push 0x100 and 0x200 at cycles 2–3 -> `state`=PRIME until first tick (cycle 15); `pwm_data`=0x100 from cycle 16; 0x200 from cycle 32.
2. Fill FIFO with 4 samples, hold `s_valid`=1 with a 5th -> `s_ready`=0 while full; 5th accepted the cycle after the next pop; samples emerge in order, one per 16 clocks.
3. Prime 2 samples, then no more input -> after 2 periods `state`=UNDERRUN, `pwm_data`=0, `underrun_cnt` increments 1,2,3 on successive ticks; push 2 samples -> RUN and first sample output on the next tick.
4. Same as 3 with PWM_SCHED_HOLD_LAST_EN -> during underrun `pwm_data` stays at the last sample (e.g. 0x7FF) instead of 0.
5. `enable` dropped mid-period with 3 samples queued -> next cycle IDLE, FIFO level 0, `pwm_data`=0, `s_ready`=0, `underrun_cnt` unchanged.
6. `rst` asserted asynchronously mid-period in RUN -> all outputs at reset values before the next clock edge; `frame_tick` next high 16 clocks after release.
